usb_xfer_loopback: RTL
======================

Name: usb_xfer_loopback

Overview:
- Parametrised endpoint-side data engine on the usb_xfer application streams (xfer_rx_*, xfer_tx_*, ctl_req/ctl_ack). It replaces fixed bench stubs: constant-byte IN data, an always-ready OUT sink and a manually driven control acknowledge.
- Three runtime modes:
  - LOOPBACK: packet-aware FIFO that echoes OUT data back as IN data.
  - PATTERN: incrementing bytes.
  - CONSTANT: fill byte.
- Also generates an automatic, delayed ctl_ack.
- Sits between usb_xfer and the application, in the ulpi_clk domain.

Parameters:
- DEPTH, 64: FIFO entries; power of two, >= 4.
- CTL_ACK_DELAY, 4: cycles from ctl_req rising edge to ctl_ack pulse; 0 disables auto-ack.
- CNT_W, 16: width of statistics counters (optional feature only).

Ports:
- clk  in  1  ulpi_clk domain clock
- rst  in  1  asynchronous, active-low reset
- mode  in  2  0=LOOPBACK, 1=PATTERN, 2=CONSTANT, 3=reserved (behaves as CONSTANT)
- fill_byte  in  8  CONSTANT-mode data byte
- pkt_len  in  11  IN packet length in bytes for PATTERN/CONSTANT; 0 is treated as 1
- ctl_req  in  1  control request pending, from usb_xfer
- ctl_ack  out  1  one-cycle acknowledge pulse
- xfer_rx_tdata  in  8
- xfer_rx_tlast  in  1
- xfer_rx_error  in  1  packet error, valid on any beat
- xfer_rx_tvalid  in  1
- xfer_rx_tready  out  1
- xfer_tx_tdata  out  8
- xfer_tx_tlast  out  1
- xfer_tx_tvalid  out  1
- xfer_tx_tready  in  1

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all pointers/counters 0, rx FSM in IDLE, mode_q=LOOPBACK.
- Storage: DEPTH x 9 bits {last, data}. Pointers wr_ptr, wr_commit, rd_ptr are log2(DEPTH)+1 bits wide and wrap naturally. full = (wr_ptr - rd_ptr == DEPTH).
- Mode sampling: mode_q <= mode only when no IN packet is in progress (tx beat index 0 and no beat pending). A mid-packet mode change takes effect after the current tlast.
- rx FSM (LOOPBACK only; other modes keep xfer_rx_tready=1 and discard data):
  - IDLE/RECV: tready = !full. Each accepted beat writes the FIFO and sets sticky err if xfer_rx_error=1.
    - On tlast with err clear: wr_commit <= wr_ptr+1.
    - On tlast with err set: wr_ptr <= wr_commit (rewind).
    - err clears after every tlast.
  - Overflow: FIFO full, packet unterminated and rd_ptr == wr_commit (no committed data to drain). Go to DISCARD and rewind wr_ptr to wr_commit.
  - DISCARD: tready=1, beats dropped; on tlast return to IDLE.
- tx path, LOOPBACK:
  - Registered output stage; tvalid only while committed data exists (rd_ptr != wr_commit or output register full).
  - Uncommitted bytes are never emitted.
  - Latency: commit at cycle N gives tvalid at N+2.
  - Output holds stable while tvalid && !tready.
- tx path, PATTERN: tvalid=1; tdata = 8-bit counter incrementing per accepted beat, wrapping 255->0 across packets; tlast on beat pkt_len-1.
- tx path, CONSTANT: tvalid=1; tdata=fill_byte; tlast as in PATTERN.
- Mode exit: switching away from LOOPBACK retains FIFO contents; emission resumes on return.
- ctl_ack:
  - A ctl_req rising edge loads a down-counter with CTL_ACK_DELAY; ctl_ack pulses for 1 cycle when it reaches 0.
  - Edges during an active countdown are ignored.
  - If ctl_req falls before expiry, the countdown aborts with no pulse.
- Simultaneous read of the last committed word and a commit: both honoured, no bubble.

Optional Feature:
- Macro: USB_XFER_LOOPBACK_STATS_EN.
- Enabled: adds outputs stat_rx_pkts, stat_rx_drops and stat_tx_pkts, each CNT_W wide, saturating, reset to 0.
  - stat_rx_pkts: committed packets.
  - stat_rx_drops: error or overflow drops.
  - stat_tx_pkts: IN tlast handshakes, all modes.
- Disabled: ports and counters absent; no other behaviour change.

Decomposition:
- Package usb_xfer_loopback_pkg: mode encodings (LB_MODE_LOOPBACK/PATTERN/CONSTANT), rx FSM state enum (IDLE, RECV, DISCARD), 9-bit entry field constants.
- One natural sub-module: usb_pkt_fifo, the commit/rewind FIFO with its pointers and output register. The top level keeps mode mux, generators, ctl_ack timer and stats.

Test Plan:
- LOOPBACK: OUT packet 0x01..0x08, tlast on 0x08, no error -> IN stream 0x01..0x08 with tlast on 0x08, first tvalid 2 cycles after the commit.
- LOOPBACK: 5-byte packet with xfer_rx_error on beat 3, then clean packet 0xAA,0xBB -> only 0xAA,0xBB emitted; stat_rx_drops=1 when enabled.
- LOOPBACK overflow, DEPTH=64: 80-byte packet with tx_tready=0 -> tready high through beat 80; no IN data; next 4-byte packet loops back intact.
- PATTERN, pkt_len=3, tready=1 for 9 beats -> data 0..8, tlast on 2, 5, 8; pkt_len=0 -> tlast every beat.
- Mode change PATTERN->CONSTANT (fill 0xDE) at beat 1 of a 4-byte packet -> beats 2,3 stay pattern, then 0xDE.
- ctl_req rise, CTL_ACK_DELAY=4 -> one-cycle ctl_ack 4 cycles later; ctl_req dropped at cycle 2 -> no ack; async reset mid-packet -> all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/usb_xfer_loopback_pkg.sv
// Shared definitions for the usb_xfer loopback/pattern data engine:
// mode encodings, OUT-side receive FSM states and FIFO entry layout.
package usb_xfer_loopback_pkg;

  localparam logic [1:0] LB_MODE_LOOPBACK = 2'd0;
  localparam logic [1:0] LB_MODE_PATTERN  = 2'd1;
  localparam logic [1:0] LB_MODE_CONSTANT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  // FIFO entry is {last, data}
  localparam int ENTRY_DATA_W   = 8;
  localparam int ENTRY_W        = 9;
  localparam int ENTRY_LAST_BIT = 8;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic last,
                                                    input logic [ENTRY_DATA_W-1:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/usb_pkt_fifo.sv
// Packet-aware commit/rewind FIFO. OUT beats are written speculatively and
// only become readable once their packet ends cleanly; errored or overflowing
// packets are rewound. A registered output stage feeds the IN stream.
module usb_pkt_fifo
  import usb_xfer_loopback_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  input  logic       lb_en,        // loopback active: OUT beats go into the FIFO
  input  logic       rd_en,        // output register may be loaded
  input  logic [7:0] rx_tdata,
  input  logic       rx_tlast,
  input  logic       rx_error,
  input  logic       rx_tvalid,
  output logic       rx_tready,
  output logic [7:0] out_tdata,
  output logic       out_tlast,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       commit_pulse,
  output logic       drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  rx_state_e          state_q;
  logic [PW-1:0]      wr_ptr_q, wr_commit_q, rd_ptr_q;
  logic               err_q, run_q, commit_q, drop_q;
  logic [ENTRY_W-1:0] out_word_q;
  logic               out_valid_q;

  logic full, ovf, accepting, rx_beat, wr_fire, err_now, load;

  // Ready/overflow decode; an overflowing beat is taken and dropped so the
  // host never sees back-pressure for a packet that cannot fit
  always_comb begin
    full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    accepting = lb_en && (state_q != DISCARD);
    ovf       = accepting && full && (rd_ptr_q == wr_commit_q);
    rx_tready = run_q && (!accepting || !full || ovf);
    rx_beat   = rx_tvalid && rx_tready;
    wr_fire   = rx_beat && accepting && !ovf;
    err_now   = err_q || rx_error;
    load      = rd_en && (rd_ptr_q != wr_commit_q) && (!out_valid_q || out_tready);
  end

  // Storage write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= make_entry(rx_tlast, rx_tdata);
  end

  // Receive FSM with write/commit pointer management
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
      commit_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
      if (!lb_en) begin
        // Leaving loopback mid-packet abandons the partial packet
        if (state_q != IDLE) begin
          wr_ptr_q <= wr_commit_q;
          err_q    <= 1'b0;
          if (state_q == RECV) drop_q <= 1'b1;
          state_q  <= (rx_beat && rx_tlast) ? IDLE : DISCARD;
        end
      end else begin
        case (state_q)
          IDLE, RECV: begin
            if (rx_beat) begin
              if (ovf) begin
                wr_ptr_q <= wr_commit_q;
                err_q    <= 1'b0;
                drop_q   <= 1'b1;
                state_q  <= rx_tlast ? IDLE : DISCARD;
              end else if (rx_tlast) begin
                err_q   <= 1'b0;
                state_q <= IDLE;
                if (err_now) begin
                  wr_ptr_q <= wr_commit_q;
                  drop_q   <= 1'b1;
                end else begin
                  wr_ptr_q    <= wr_ptr_q + 1'b1;
                  wr_commit_q <= wr_ptr_q + 1'b1;
                  commit_q    <= 1'b1;
                end
              end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                err_q    <= err_now;
                state_q  <= RECV;
              end
            end
          end
          DISCARD: begin
            if (rx_beat && rx_tlast) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Registered read / output stage; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_word_q  <= mem[rd_ptr_q[AW-1:0]];
      out_valid_q <= 1'b1;
      rd_ptr_q    <= rd_ptr_q + 1'b1;
    end else if (out_valid_q && out_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_tdata    = out_word_q[ENTRY_DATA_W-1:0];
  assign out_tlast    = out_word_q[ENTRY_LAST_BIT];
  assign out_tvalid   = out_valid_q;
  assign commit_pulse = commit_q;
  assign drop_pulse   = drop_q;

endmodule

// File: rtl/usb_xfer_loopback.sv
// Endpoint-side data engine for the usb_xfer application streams: loopback
// FIFO, incrementing-pattern and constant-byte IN generators, and an
// automatic delayed control acknowledge.
// Optional statistics counters are built when USB_XFER_LOOPBACK_STATS_EN is defined.
module usb_xfer_loopback
  import usb_xfer_loopback_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int CTL_ACK_DELAY = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,            // asynchronous, active-low
  input  logic [1:0]       mode,
  input  logic [7:0]       fill_byte,
  input  logic [10:0]      pkt_len,
  input  logic             ctl_req,
  output logic             ctl_ack,
`ifdef USB_XFER_LOOPBACK_STATS_EN
  output logic [CNT_W-1:0] stat_rx_pkts,
  output logic [CNT_W-1:0] stat_rx_drops,
  output logic [CNT_W-1:0] stat_tx_pkts,
`endif
  input  logic [7:0]       xfer_rx_tdata,
  input  logic             xfer_rx_tlast,
  input  logic             xfer_rx_error,
  input  logic             xfer_rx_tvalid,
  output logic             xfer_rx_tready,
  output logic [7:0]       xfer_tx_tdata,
  output logic             xfer_tx_tlast,
  output logic             xfer_tx_tvalid,
  input  logic             xfer_tx_tready
);

  localparam int ACK_W = $clog2(CTL_ACK_DELAY + 2);

  logic [1:0]       mode_q, mode_d;
  logic [10:0]      tx_idx_q, tx_idx_d;
  logic [7:0]       pat_q, pat_d;
  logic             ctl_req_q, ack_busy_q, ack_busy_d, ctl_ack_q, ctl_ack_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

  logic        lb_active, rd_en, tx_hs, gen_last;
  logic [10:0] len_m1;
  logic [7:0]  fifo_tdata;
  logic        fifo_tlast, fifo_tvalid, commit_pulse, drop_pulse;

  assign lb_active = (mode_q == LB_MODE_LOOPBACK);
  // Do not load a new loopback word on the edge that leaves loopback
  assign rd_en     = lb_active && (mode_d == LB_MODE_LOOPBACK);

  usb_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .lb_en        (lb_active),
    .rd_en        (rd_en),
    .rx_tdata     (xfer_rx_tdata),
    .rx_tlast     (xfer_rx_tlast),
    .rx_error     (xfer_rx_error),
    .rx_tvalid    (xfer_rx_tvalid),
    .rx_tready    (xfer_rx_tready),
    .out_tdata    (fifo_tdata),
    .out_tlast    (fifo_tlast),
    .out_tvalid   (fifo_tvalid),
    .out_tready   (xfer_tx_tready),
    .commit_pulse (commit_pulse),
    .drop_pulse   (drop_pulse)
  );

  // IN stream mux and generator/mode next-state
  always_comb begin
    len_m1   = (pkt_len == 11'd0) ? 11'd0 : pkt_len - 11'd1;
    gen_last = (tx_idx_q >= len_m1);
    case (mode_q)
      LB_MODE_LOOPBACK: begin
        xfer_tx_tvalid = fifo_tvalid;
        xfer_tx_tdata  = fifo_tdata;
        xfer_tx_tlast  = fifo_tlast;
      end
      LB_MODE_PATTERN: begin
        xfer_tx_tvalid = 1'b1;
        xfer_tx_tdata  = pat_q;
        xfer_tx_tlast  = gen_last;
      end
      default: begin
        xfer_tx_tvalid = 1'b1;
        xfer_tx_tdata  = fill_byte;
        xfer_tx_tlast  = gen_last;
      end
    endcase
    tx_hs    = xfer_tx_tvalid && xfer_tx_tready;
    tx_idx_d = tx_idx_q;
    pat_d    = pat_q;
    if (tx_hs) begin
      tx_idx_d = xfer_tx_tlast ? 11'd0 : tx_idx_q + 11'd1;
      if (mode_q == LB_MODE_PATTERN) pat_d = pat_q + 8'd1;
    end
    // Mode only changes at an IN packet boundary
    mode_d = mode_q;
    if ((tx_hs && xfer_tx_tlast) || (tx_idx_q == 11'd0 && !fifo_tvalid && !tx_hs))
      mode_d = mode;
  end

  // Control acknowledge timer: rising edge arms, falling request aborts
  always_comb begin
    ack_cnt_d  = ack_cnt_q;
    ack_busy_d = ack_busy_q;
    ctl_ack_d  = 1'b0;
    if (ack_busy_q) begin
      if (!ctl_req) begin
        ack_busy_d = 1'b0;
      end else if (ack_cnt_q <= ACK_W'(1)) begin
        ack_busy_d = 1'b0;
        ack_cnt_d  = '0;
        ctl_ack_d  = 1'b1;
      end else begin
        ack_cnt_d = ack_cnt_q - 1'b1;
      end
    end else if (ctl_req && !ctl_req_q && (CTL_ACK_DELAY != 0)) begin
      ack_busy_d = 1'b1;
      ack_cnt_d  = ACK_W'(CTL_ACK_DELAY);
    end
  end

  // Mode, generator and timer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= LB_MODE_LOOPBACK;
      tx_idx_q   <= '0;
      pat_q      <= '0;
      ctl_req_q  <= 1'b0;
      ack_busy_q <= 1'b0;
      ack_cnt_q  <= '0;
      ctl_ack_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      tx_idx_q   <= tx_idx_d;
      pat_q      <= pat_d;
      ctl_req_q  <= ctl_req;
      ack_busy_q <= ack_busy_d;
      ack_cnt_q  <= ack_cnt_d;
      ctl_ack_q  <= ctl_ack_d;
    end
  end

  assign ctl_ack = ctl_ack_q;

`ifdef USB_XFER_LOOPBACK_STATS_EN
  logic [CNT_W-1:0] rx_pkts_q, rx_pkts_d, rx_drops_q, rx_drops_d, tx_pkts_q, tx_pkts_d;

  // Saturating packet statistics
  always_comb begin
    rx_pkts_d  = rx_pkts_q;
    rx_drops_d = rx_drops_q;
    tx_pkts_d  = tx_pkts_q;
    if (commit_pulse && rx_pkts_q != '1)          rx_pkts_d  = rx_pkts_q + 1'b1;
    if (drop_pulse && rx_drops_q != '1)           rx_drops_d = rx_drops_q + 1'b1;
    if (tx_hs && xfer_tx_tlast && tx_pkts_q != '1) tx_pkts_d = tx_pkts_q + 1'b1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_pkts_q  <= '0;
      rx_drops_q <= '0;
      tx_pkts_q  <= '0;
    end else begin
      rx_pkts_q  <= rx_pkts_d;
      rx_drops_q <= rx_drops_d;
      tx_pkts_q  <= tx_pkts_d;
    end
  end

  assign stat_rx_pkts  = rx_pkts_q;
  assign stat_rx_drops = rx_drops_q;
  assign stat_tx_pkts  = tx_pkts_q;
`else
  logic unused_stat_pulses;
  assign unused_stat_pulses = commit_pulse ^ drop_pulse;
`endif

endmodule
